fdre_pipe: RTL and testbench

Parametrised elastic register pipeline that generalises the single-bit FD/FDR flip-flop wrappers into a WIDTH-bit, DEPTH-stage delay line. It adds clock enable, synchronous reset, and a valid/ready handshake with bubble collapsing. A flush clears in-flight data and an occupancy count tracks how many stages hold data. It sits in the soc/xilinx wrapper layer and is used wherever fabric logic needs retiming with backpressure, such as the SPI-to-bus path and sensor-sample capture.

---
 rtl/fdre_pipe_pkg.sv | 12 +
 rtl/fdre_pipe_stage.sv | 31 +++
 rtl/fdre_pipe.sv | 101 ++++++++++
 tb/tb_fdre_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdre_pipe_pkg.sv
// Shared constants and helpers for the fdre_pipe elastic register pipeline.
package fdre_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fdre_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register with CE, synchronous reset and load enable,
// plus a valid bit with a clear input that works independently of CE.
module fdre_pipe_stage
  import fdre_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RESET_VALUE;
      valid <= 1'b0;
    end else begin
      if (ce && load) q <= d;
      // clr wins so a flush empties the stage even when CE is low
      if (clr)              valid <= 1'b0;
      else if (ce && load)  valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fdre_pipe.sv
// WIDTH-bit, DEPTH-stage elastic delay line with valid/ready handshake, bubble collapsing,
// flush and a registered occupancy count.
module fdre_pipe
  import fdre_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         C,
  input  logic                         R,
  input  logic                         CE,
  input  logic                         FLUSH,
  input  logic [WIDTH-1:0]             D,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  output logic [WIDTH-1:0]             Q,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [occ_width(DEPTH)-1:0]  OCCUPANCY
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] moving;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clr;
  logic [WIDTH-1:0] data [DEPTH];
  logic             active;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ;

  assign active   = CE & ~R & ~FLUSH;
  assign out_xfer = active & v[DEPTH-1] & OUT_READY;
  assign IN_READY = active & free[0];
  assign in_xfer  = IN_VALID & IN_READY;

  // Ready ripples from the output back to the input; a valid stage advances
  // whenever its successor is empty or itself advancing, which closes gaps.
  always_comb begin
    moving = '0;
    free   = '0;
    load   = '0;
    clr    = '0;
    moving[DEPTH-1] = out_xfer;
    free[DEPTH-1]   = ~v[DEPTH-1] | out_xfer;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      moving[k] = active & v[k] & free[k+1];
      free[k]   = ~v[k] | moving[k];
    end
    load[0] = in_xfer;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = moving[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      clr[k] = FLUSH | (moving[k] & ~load[k]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign din = D;
    end else begin : g_body
      assign din = data[k-1];
    end

    fdre_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (C),
      .rst   (R),
      .ce    (CE),
      .load  (load[k]),
      .clr   (clr[k]),
      .d     (din),
      .q     (data[k]),
      .valid (v[k])
    );
  end

  // Counter tracks transfers rather than summing v, so it stays a plain register.
  always_ff @(posedge C) begin
    if (R || FLUSH) begin
      occ <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ <= occ + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ <= occ - OCC_W'(1);
    end
  end

  assign Q         = data[DEPTH-1];
  assign OUT_VALID = v[DEPTH-1] & ~FLUSH & ~R;
  assign OCCUPANCY = occ;

endmodule

// File: tb/tb_fdre_pipe.sv
// Bench for fdre_pipe: a DEPTH=3 and a DEPTH=1 instance checked every cycle against a
// word-position queue model, plus hand-computed expectations for the directed scenarios.
module tb_fdre_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      r_i, ce_i, fl_i, iv_i, or_i, ir_o, ov_o;
  logic [1:0][7:0] d_i, q_o;
  logic [1:0]      occ3;
  logic [0:0]      occ1;

  int n_cmp = 0;
  int n_bad = 0;

  fdre_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) dut3 (
    .C(clk), .R(r_i[0]), .CE(ce_i[0]), .FLUSH(fl_i[0]), .D(d_i[0]),
    .IN_VALID(iv_i[0]), .IN_READY(ir_o[0]), .Q(q_o[0]), .OUT_VALID(ov_o[0]),
    .OUT_READY(or_i[0]), .OCCUPANCY(occ3)
  );

  fdre_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h3C)) dut1 (
    .C(clk), .R(r_i[1]), .CE(ce_i[1]), .FLUSH(fl_i[1]), .D(d_i[1]),
    .IN_VALID(iv_i[1]), .IN_READY(ir_o[1]), .Q(q_o[1]), .OUT_VALID(ov_o[1]),
    .OUT_READY(or_i[1]), .OCCUPANCY(occ1)
  );

  // Model: ordered list of words (oldest first), each with its stage position.
  int         depth_of [2] = '{3, 1};
  logic [7:0] rv_of    [2] = '{8'hA5, 8'h3C};
  int         cnt      [2] = '{0, 0};
  int         pos      [2][4];
  logic [7:0] dat      [2][4];
  logic [7:0] qlast    [2];
  logic [1:0] armed = '0;
  int         np [4];
  logic [7:0] nd [4];
  int         ncnt;

  // Advance every word as far as the word ahead of it allows; return whether stage 0 is free.
  function automatic bit plan(int ii, logic ordy);
    int dep;
    int ahead;
    dep   = depth_of[ii];
    ahead = dep;
    ncnt  = 0;
    for (int i = 0; i < cnt[ii]; i++) begin
      int p;
      p = pos[ii][i];
      if (p == dep - 1 && ordy) continue;
      if (p < dep - 1 && ahead > p + 1) p++;
      np[ncnt] = p;
      nd[ncnt] = dat[ii][i];
      ncnt++;
      ahead = p;
    end
    return (ncnt == 0) || (np[ncnt-1] > 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check(int ii);
    bit          active, exp_ir, exp_ov;
    logic [31:0] occ_v;
    if (!armed[ii]) return;
    active = ce_i[ii] & ~r_i[ii] & ~fl_i[ii];
    exp_ir = active & plan(ii, or_i[ii]);
    exp_ov = (cnt[ii] > 0) && (pos[ii][0] == depth_of[ii] - 1) && !fl_i[ii] && !r_i[ii];
    occ_v  = (ii == 0) ? 32'(occ3) : 32'(occ1);
    chk($sformatf("in_ready[d%0d]", depth_of[ii]), 32'(ir_o[ii]), 32'(exp_ir));
    chk($sformatf("out_valid[d%0d]", depth_of[ii]), 32'(ov_o[ii]), 32'(exp_ov));
    chk($sformatf("q[d%0d]", depth_of[ii]), 32'(q_o[ii]), 32'(qlast[ii]));
    chk($sformatf("occupancy[d%0d]", depth_of[ii]), occ_v, 32'(cnt[ii]));
  endtask

  task automatic update(int ii);
    int dep;
    bit rm;
    dep = depth_of[ii];
    if (r_i[ii]) begin
      cnt[ii] = 0; qlast[ii] = rv_of[ii]; armed[ii] = 1'b1;
      return;
    end
    if (!armed[ii]) return;
    if (fl_i[ii]) begin
      cnt[ii] = 0;
      return;
    end
    if (!ce_i[ii]) return;
    rm = plan(ii, or_i[ii]);
    for (int i = 0; i < ncnt; i++) begin
      pos[ii][i] = np[i];
      dat[ii][i] = nd[i];
      if (np[i] == dep - 1) qlast[ii] = nd[i];
    end
    cnt[ii] = ncnt;
    if (iv_i[ii] && rm) begin
      pos[ii][cnt[ii]] = 0;
      dat[ii][cnt[ii]] = d_i[ii];
      cnt[ii]++;
      if (dep == 1) qlast[ii] = d_i[ii];
    end
  endtask

  task automatic cycle();
    #2;
    check(0);
    check(1);
    @(posedge clk);
    update(0);
    update(1);
    #1;
  endtask

  task automatic push0(logic [7:0] val);
    iv_i[0] = 1'b1;
    d_i[0]  = val;
    cycle();
    iv_i[0] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (armed[0]) begin
      n_cmp++;
      assert ($countones(dut3.v) == int'(occ3)) else begin
        n_bad++;
        $display("FAIL occ_popcount[d3]: actual %0d required %0d", occ3, $countones(dut3.v));
      end
    end
    if (armed[1]) begin
      n_cmp++;
      assert ($countones(dut1.v) == int'(occ1)) else begin
        n_bad++;
        $display("FAIL occ_popcount[d1]: actual %0d required %0d", occ1, $countones(dut1.v));
      end
    end
  end

  logic [7:0] exp_l [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    r_i = '1; ce_i = '1; fl_i = '0; iv_i = '0; or_i = 2'b01; d_i = '0;
    cycle();
    cycle();
    r_i = '0;
    #1;
    chk("rst_q", 32'(q_o[0]), 32'h A5);
    chk("rst_out_valid", 32'(ov_o[0]), 0);
    chk("rst_occ", 32'(occ3), 0);
    chk("rst_in_ready", 32'(ir_o[0]), 1);

    // latency through an empty pipe
    iv_i[0] = 1'b1;
    d_i[0] = 8'h11; cycle();
    d_i[0] = 8'h22; cycle();
    d_i[0] = 8'h33;
    #1; chk("lat_ov_early", 32'(ov_o[0]), 0);
    cycle();
    iv_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lat_ov", 32'(ov_o[0]), 1);
      chk("lat_q", 32'(q_o[0]), 32'(exp_l[k]));
      cycle();
    end
    #1; chk("lat_ov_after", 32'(ov_o[0]), 0);

    // stall with a bubble, then drain
    or_i[0] = 1'b0;
    push0(8'h01);
    cycle();
    push0(8'h02);
    push0(8'h03);
    iv_i[0] = 1'b1; d_i[0] = 8'h04;
    #1;
    chk("stall_occ", 32'(occ3), 3);
    chk("stall_in_ready", 32'(ir_o[0]), 0);
    cycle();
    iv_i[0] = 1'b0; or_i[0] = 1'b1;
    #1;
    chk("drain_in_ready", 32'(ir_o[0]), 1);
    chk("drain_q0", 32'(q_o[0]), 32'h01);
    cycle();
    #1; chk("drain_q1", 32'(q_o[0]), 32'h02); chk("drain_ov1", 32'(ov_o[0]), 1);
    cycle();
    #1; chk("drain_q2", 32'(q_o[0]), 32'h03); chk("drain_ov2", 32'(ov_o[0]), 1);
    cycle();
    #1; chk("drain_empty", 32'(ov_o[0]), 0);

    // full with simultaneous in/out transfer
    or_i[0] = 1'b0;
    push0(8'h50); push0(8'h51); push0(8'h52);
    or_i[0] = 1'b1; iv_i[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d_i[0] = 8'(8'h60 + k);
      #1;
      chk("full_occ", 32'(occ3), 3);
      chk("full_in_ready", 32'(ir_o[0]), 1);
      chk("full_q", 32'(q_o[0]), (k < 3) ? 32'(8'h50 + k) : 32'(8'h60 + k - 3));
      cycle();
    end
    iv_i[0] = 1'b0;
    repeat (4) cycle();

    // CE gating
    or_i[0] = 1'b0;
    push0(8'h70); push0(8'h71);
    cycle();
    ce_i[0] = 1'b0; or_i[0] = 1'b1; iv_i[0] = 1'b1; d_i[0] = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ce_in_ready", 32'(ir_o[0]), 0);
      chk("ce_q", 32'(q_o[0]), 32'h70);
      chk("ce_occ", 32'(occ3), 2);
      cycle();
    end
    ce_i[0] = 1'b1; iv_i[0] = 1'b0;
    #1; chk("ce_resume_q0", 32'(q_o[0]), 32'h70);
    cycle();
    #1; chk("ce_resume_q1", 32'(q_o[0]), 32'h71); chk("ce_resume_ov", 32'(ov_o[0]), 1);
    cycle();
    #1; chk("ce_resume_empty", 32'(ov_o[0]), 0);

    // flush keeps data, reset reloads it
    or_i[0] = 1'b0;
    push0(8'h80); push0(8'h81); push0(8'h82);
    fl_i[0] = 1'b1; iv_i[0] = 1'b1; d_i[0] = 8'h99;
    #1;
    chk("flush_in_ready", 32'(ir_o[0]), 0);
    chk("flush_out_valid", 32'(ov_o[0]), 0);
    cycle();
    fl_i[0] = 1'b0; iv_i[0] = 1'b0;
    #1;
    chk("flush_occ", 32'(occ3), 0);
    chk("flush_q", 32'(q_o[0]), 32'h80);
    push0(8'h90); push0(8'h91); push0(8'h92);
    r_i[0] = 1'b1; fl_i[0] = 1'b1; iv_i[0] = 1'b1;
    #1;
    chk("rflush_in_ready", 32'(ir_o[0]), 0);
    chk("rflush_out_valid", 32'(ov_o[0]), 0);
    cycle();
    r_i[0] = 1'b0; fl_i[0] = 1'b0; iv_i[0] = 1'b0;
    #1;
    chk("rflush_q", 32'(q_o[0]), 32'h A5);
    chk("rflush_occ", 32'(occ3), 0);

    // randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      for (int ii = 0; ii < 2; ii++) begin
        r_i[ii]  = ($urandom_range(0, 49) == 0);
        fl_i[ii] = ($urandom_range(0, 29) == 0);
        ce_i[ii] = ($urandom_range(0, 7) != 0);
        iv_i[ii] = 1'($urandom_range(0, 1));
        or_i[ii] = 1'($urandom_range(0, 1));
        d_i[ii]  = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
